// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result handshake bundle for seq_mult.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the multiplier (drives in_ready, out_valid, pout)
// Signals: in_valid/in_ready + xin, yin, sgn (operand channel),
//          out_valid/out_ready + pout (2*WIDTH-bit result channel).
interface seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     xin;
    logic [WIDTH-1:0]     yin;
    logic                 sgn;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   pout;

    modport master (
        output in_valid, xin, yin, sgn, out_ready,
        input  in_ready, out_valid, pout
    );

    modport slave (
        input  in_valid, xin, yin, sgn, out_ready,
        output in_ready, out_valid, pout
    );
endinterface

// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier, one multiplier bit per clock,
// LSB first. Unsigned or two's-complement operands (sgn sampled with the
// operands); full 2*WIDTH-bit product. Latency WIDTH cycles from acceptance
// to out_valid.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_mult_if.slave (operand and result valid/ready channels)
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mult_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      xr;     // multiplicand, already extended to PW bits
    logic [PW-1:0]      acc;
    logic [PW-1:0]      pp;
    logic [WIDTH-1:0]   yr;
    logic               sr;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                // Gate with rst_n so in_ready reads low while reset is held.
                bus.in_ready = rst_n;
                accept       = bus.in_valid && rst_n;
                if (accept) state_nxt = CALC;
            end
            CALC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign pp   = yr[cnt] ? (xr << cnt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr  <= '0;
            yr  <= '0;
            sr  <= 1'b0;
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            xr  <= bus.sgn ? {{WIDTH{bus.xin[WIDTH-1]}}, bus.xin}
                           : {{WIDTH{1'b0}}, bus.xin};
            yr  <= bus.yin;
            sr  <= bus.sgn;
            cnt <= '0;
            acc <= '0;
        end else if (state == CALC) begin
            // Signed MSB carries weight -2^(WIDTH-1): subtract its partial product.
            acc <= (last && sr) ? acc - pp : acc + pp;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // acc only changes in CALC, so it holds the last product through DONE
    // and afterwards until the next acceptance.
    assign bus.pout = acc;
endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          sel = 1;          // 0:W4 1:W8 2:W12 3:W16
    logic        s_in_valid = 1'b0;
    logic        s_out_ready = 1'b0;
    logic [15:0] s_xin = '0;
    logic [15:0] s_yin = '0;
    logic        s_sgn = 1'b0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_pout;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mult_if #(.WIDTH(4))  b4 ();
    seq_mult_if #(.WIDTH(8))  b8 ();
    seq_mult_if #(.WIDTH(12)) b12 ();
    seq_mult_if #(.WIDTH(16)) b16 ();

    seq_mult #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    seq_mult #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    seq_mult #(.WIDTH(12)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12));
    seq_mult #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    assign b4.in_valid   = s_in_valid && (sel == 0);
    assign b4.out_ready  = s_out_ready && (sel == 0);
    assign b4.xin        = s_xin[3:0];
    assign b4.yin        = s_yin[3:0];
    assign b4.sgn        = s_sgn;
    assign b8.in_valid   = s_in_valid && (sel == 1);
    assign b8.out_ready  = s_out_ready && (sel == 1);
    assign b8.xin        = s_xin[7:0];
    assign b8.yin        = s_yin[7:0];
    assign b8.sgn        = s_sgn;
    assign b12.in_valid  = s_in_valid && (sel == 2);
    assign b12.out_ready = s_out_ready && (sel == 2);
    assign b12.xin       = s_xin[11:0];
    assign b12.yin       = s_yin[11:0];
    assign b12.sgn       = s_sgn;
    assign b16.in_valid  = s_in_valid && (sel == 3);
    assign b16.out_ready = s_out_ready && (sel == 3);
    assign b16.xin       = s_xin;
    assign b16.yin       = s_yin;
    assign b16.sgn       = s_sgn;

    always_comb begin
        s_in_ready  = 1'b0;
        s_out_valid = 1'b0;
        s_pout      = '0;
        case (sel)
            0: begin s_in_ready = b4.in_ready;  s_out_valid = b4.out_valid;  s_pout = 32'(b4.pout);  end
            1: begin s_in_ready = b8.in_ready;  s_out_valid = b8.out_valid;  s_pout = 32'(b8.pout);  end
            2: begin s_in_ready = b12.in_ready; s_out_valid = b12.out_valid; s_pout = 32'(b12.pout); end
            default: begin s_in_ready = b16.in_ready; s_out_valid = b16.out_valid; s_pout = 32'(b16.pout); end
        endcase
    end

    // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                            input logic [15:0] y, input logic s);
        longint a, b, m;
        a = longint'(x) & ((longint'(1) << w) - 1);
        b = longint'(y) & ((longint'(1) << w) - 1);
        if (s && a >= (longint'(1) << (w - 1))) a = a - (longint'(1) << w);
        if (s && b >= (longint'(1) << (w - 1))) b = b - (longint'(1) << w);
        m = a * b;
        return 32'(m & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Runs one transaction on the selected DUT. Starts and ends at a negedge.
    // lat = edges from acceptance to out_valid; hold_ok clears if the result
    // moved during stalls or the post-handshake state is not IDLE.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input int stall, output logic [31:0] p, output int lat,
                         output bit hold_ok);
        int n;
        hold_ok = 1'b1;
        n = 0;
        while (!s_in_ready && n < 200) begin @(negedge clk); n++; end
        s_xin = x; s_yin = y; s_sgn = s;
        s_in_valid  = 1'b1;
        s_out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        s_xin = 16'($urandom);
        s_yin = 16'($urandom);
        s_sgn = 1'($urandom);
        lat = 0;
        while (!s_out_valid && lat < 200) begin @(negedge clk); lat++; end
        p = s_pout;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!s_out_valid || s_pout !== p || s_in_ready) hold_ok = 1'b0;
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        if (s_out_valid || !s_in_ready) hold_ok = 1'b0;
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            checks++;
            if (s_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready w%0d got %b want 0", 4*(k+1), s_in_ready); end
            checks++;
            if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid w%0d got %b want 0", 4*(k+1), s_out_valid); end
            checks++;
            if (s_pout !== 32'h0) begin errors++; $display("FAIL reset_pout w%0d got %h want 0", 4*(k+1), s_pout); end
        end
        sel = 1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", s_in_ready); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] xs [6] = '{16'd50, 16'd255, 16'd0, 16'hFD, 16'h80, 16'h7F};
        logic [15:0] ys [6] = '{16'd100, 16'd255, 16'd200, 16'h05, 16'h80, 16'h80};
        logic        ss [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] ex [6] = '{32'h1388, 32'hFE01, 32'h0000, 32'hFFF1, 32'h4000, 32'hC080};
        logic [31:0] p;
        int lat;
        bit ok;
        sel = 1;
        for (int i = 0; i < 6; i++) begin
            do_op(xs[i], ys[i], ss[i], 0, p, lat, ok);
            checks++;
            if (p !== ex[i]) begin errors++; $display("FAIL directed_prod[%0d] got %h want %h", i, p, ex[i]); end
            checks++;
            if (lat != 8) begin errors++; $display("FAIL directed_lat[%0d] got %0d want 8", i, lat); end
            checks++;
            if (!ok) begin errors++; $display("FAIL directed_return_idle[%0d] got 0 want 1", i); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [3] = '{16'd255, 16'd0, 16'd50};
        logic [15:0] ys [3] = '{16'd255, 16'd200, 16'd100};
        logic [31:0] ex [3] = '{32'hFE01, 32'h0000, 32'h1388};
        int t [3];
        int n;
        sel = 1;
        s_out_ready = 1'b1;
        s_sgn = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!s_in_ready && n < 50) begin @(negedge clk); n++; end
            s_xin = xs[k]; s_yin = ys[k];
            s_in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            t[k] = cyc;
            n = 0;
            while (!s_out_valid && n < 50) begin @(negedge clk); n++; end
            checks++;
            if (s_pout !== ex[k]) begin errors++; $display("FAIL b2b_prod[%0d] got %h want %h", k, s_pout, ex[k]); end
        end
        s_in_valid = 1'b0;
        @(negedge clk);
        s_out_ready = 1'b0;
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (t[k] - t[k-1] != 10) begin errors++; $display("FAIL b2b_interval[%0d] got %0d want 10", k, t[k] - t[k-1]); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] p;
        int n;
        sel = 1;
        s_out_ready = 1'b0;
        s_xin = 16'h12; s_yin = 16'h34; s_sgn = 1'b0;
        s_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 50) begin @(negedge clk); n++; end
        p = s_pout;
        checks++;
        if (p !== 32'h03A8) begin errors++; $display("FAIL bp_prod got %h want 03a8", p); end
        s_xin = 16'h07; s_yin = 16'h09; s_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (s_out_valid !== 1'b1 || s_pout !== 32'h03A8 || s_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b p=%h r=%b want v=1 p=03a8 r=0", i, s_out_valid, s_pout, s_in_ready);
            end
        end
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", s_out_valid, s_in_ready);
        end
        checks++;
        if (s_pout !== 32'h03A8) begin errors++; $display("FAIL bp_pout_kept got %h want 03a8", s_pout); end
        n = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (s_out_valid) n++; end
        checks++;
        if (n != 0) begin errors++; $display("FAIL bp_ignored_op got %0d valid cycles want 0", n); end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] p;
        int lat;
        bit ok;
        sel = 1;
        s_xin = 16'd255; s_yin = 16'd255; s_sgn = 1'b0;
        s_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", s_out_valid); end
        checks++;
        if (s_pout !== 32'h0) begin errors++; $display("FAIL midreset_pout got %h want 0", s_pout); end
        checks++;
        if (s_in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got %b want 0", s_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'd30, 16'd40, 1'b0, 0, p, lat, ok);
        checks++;
        if (p !== 32'h04B0) begin errors++; $display("FAIL midreset_prod got %h want 04b0", p); end
        checks++;
        if (lat != 8) begin errors++; $display("FAIL midreset_lat got %0d want 8", lat); end
    endtask

    task automatic test_sweep(input int k, input int nvec);
        logic [31:0] p, e;
        logic [15:0] x, y;
        logic s;
        int lat, stall, w;
        bit ok;
        sel = k;
        w = 4 * (k + 1);
        @(negedge clk);
        for (int i = 0; i < nvec; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            s = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            e = ref_mul(w, x, y, s);
            do_op(x, y, s, stall, p, lat, ok);
            checks++;
            if (p !== e) begin errors++; $display("FAIL sweep_w%0d_prod[%0d] x=%h y=%h s=%b got %h want %h", w, i, x, y, s, p, e); end
            checks++;
            if (lat != w) begin errors++; $display("FAIL sweep_w%0d_lat[%0d] got %0d want %0d", w, i, lat, w); end
            checks++;
            if (!ok) begin errors++; $display("FAIL sweep_w%0d_hold[%0d] got 0 want 1", w, i); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_calc();
        test_sweep(0, 1000);
        test_sweep(1, 200);
        test_sweep(2, 1000);
        test_sweep(3, 1000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
